// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall / trap sequencer for a 6-stage in-order pipeline.
//
// Produces the per-stage stall vector, the global flush and the PC redirect.
// A small FSM tracks an outstanding LSU access (with a timeout that raises an
// access fault) and a one-cycle trap-redirect state.
//
// Parameters
//   XLEN        data / PC width
//   MEM_TIMEOUT maximum number of MEM_WAIT cycles before an access fault
//
// Ports
//   ck_i           clock, rising edge
//   rs_i           synchronous active-high reset
//   stall_req_id_i load-use hazard from ID
//   stall_req_ex_i multi-cycle EX operation busy
//   mem_req_i      LSU access pending
//   mem_ack_i      LSU access complete
//   exception_i    MEM-stage exception vector, non-zero = trap
//   mtvec_i        trap vector base
//   mem_pc_i       PC of the MEM-stage instruction
//   stall_o        stall vector {WB,MEM,EX,ID,IF,PC}, 1 = stop
//   flush_o        flush all pipeline registers
//   new_pc_we_o    PC redirect strobe
//   new_pc_o       PC redirect target (registered)
//   epc_o          PC of the trapping instruction (registered)
//   mem_fault_o    one-cycle LSU timeout fault pulse
//   stall_cnt_o    saturating count of cycles with any stage stalled
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            ck_i,
  input  logic            rs_i,
  input  logic            stall_req_id_i,
  input  logic            stall_req_ex_i,
  input  logic            mem_req_i,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] exception_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mem_pc_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic            new_pc_we_o,
  output logic [XLEN-1:0] new_pc_o,
  output logic [XLEN-1:0] epc_o,
  output logic            mem_fault_o,
  output logic [31:0]     stall_cnt_o
);

  // Timeout counter must be able to hold MEM_TIMEOUT itself.
  localparam int unsigned TmoW = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(MEM_TIMEOUT);
  localparam logic [TmoW-1:0] TmoOne = TmoW'(1);

  // Stall patterns: a stalled stage also holds every stage upstream of it.
  localparam logic [5:0] StallAll  = 6'b111111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallNone = 6'b000000;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StTrap    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] new_pc_q, new_pc_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic            trap_req;
  logic            capture;

  assign trap_req = |exception_i;

  // ---------------------------------------------------------------------------
  // Next-state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    stall_o     = StallNone;
    flush_o     = 1'b0;
    new_pc_we_o = 1'b0;
    mem_fault_o = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (trap_req) begin
          // Exception outranks everything, including a same-cycle ack.
          stall_o = StallAll;
          capture = 1'b1;
          state_d = StTrap;
        end else if (mem_req_i && !mem_ack_i) begin
          stall_o = StallMem;
          tmo_d   = TmoOne;
          state_d = StMemWait;
        end else if (stall_req_ex_i) begin
          stall_o = StallEx;
        end else if (stall_req_id_i) begin
          // Freeze PC/IF/ID; EX receives a bubble.
          stall_o = StallId;
        end
      end

      StMemWait: begin
        if (trap_req) begin
          stall_o = StallAll;
          capture = 1'b1;
          tmo_d   = '0;
          state_d = StTrap;
        end else if (mem_ack_i) begin
          // Access completes this cycle, so the pipeline may advance now.
          tmo_d   = '0;
          state_d = StRun;
        end else if (tmo_q == TmoMax) begin
          stall_o     = StallMem;
          mem_fault_o = 1'b1;
          capture     = 1'b1;
          tmo_d       = '0;
          state_d     = StTrap;
        end else begin
          stall_o = StallMem;
          tmo_d   = tmo_q + TmoOne;
        end
      end

      StTrap: begin
        // Exceptions arriving here belong to squashed instructions.
        flush_o     = 1'b1;
        new_pc_we_o = 1'b1;
        state_d     = StRun;
      end

      default: begin
        state_d = StRun;
        tmo_d   = '0;
      end
    endcase

    // Reset wins over any in-flight trap or wait.
    if (rs_i) begin
      state_d     = StRun;
      tmo_d       = '0;
      stall_o     = StallNone;
      flush_o     = 1'b0;
      new_pc_we_o = 1'b0;
      mem_fault_o = 1'b0;
      capture     = 1'b0;
    end
  end

  always_comb begin
    epc_d    = epc_q;
    new_pc_d = new_pc_q;
    if (capture) begin
      epc_d    = mem_pc_i;
      new_pc_d = mtvec_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != StallNone) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      state_q     <= StRun;
      tmo_q       <= '0;
      epc_q       <= '0;
      new_pc_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      epc_q       <= epc_d;
      new_pc_q    <= new_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign epc_o       = epc_q;
  assign new_pc_o    = new_pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Per-cycle combinational expectations are queued when stimulus is driven and
// compared by a monitor at the falling edge; registered outputs are checked
// just after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int unsigned XLEN = 32;

  logic            ck_i = 1'b0;
  logic            rs_i;
  logic            stall_req_id_i;
  logic            stall_req_ex_i;
  logic            mem_req_i;
  logic            mem_ack_i;
  logic [XLEN-1:0] exception_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mem_pc_i;
  logic [5:0]      stall_o;
  logic            flush_o;
  logic            new_pc_we_o;
  logic [XLEN-1:0] new_pc_o;
  logic [XLEN-1:0] epc_o;
  logic            mem_fault_o;
  logic [31:0]     stall_cnt_o;

  pipe_ctrl #(
    .XLEN        (XLEN),
    .MEM_TIMEOUT (15)
  ) dut (
    .ck_i           (ck_i),
    .rs_i           (rs_i),
    .stall_req_id_i (stall_req_id_i),
    .stall_req_ex_i (stall_req_ex_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .exception_i    (exception_i),
    .mtvec_i        (mtvec_i),
    .mem_pc_i       (mem_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_we_o    (new_pc_we_o),
    .new_pc_o       (new_pc_o),
    .epc_o          (epc_o),
    .mem_fault_o    (mem_fault_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 ck_i = ~ck_i;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic       flush;
    logic       we;
    logic       fault;
  } exp_t;

  typedef struct {
    string       name;
    logic        id;
    logic        ex;
    logic        req;
    logic        ack;
    logic [31:0] exc;
    logic [5:0]  stall;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge ck_i) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if ({stall_o, flush_o, new_pc_we_o, mem_fault_o} !==
          {mon_e.stall, mon_e.flush, mon_e.we, mon_e.fault}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b we=%b fault=%b, want stall=%b flush=%b we=%b fault=%b",
                 mon_e.name, stall_o, flush_o, new_pc_we_o, mem_fault_o,
                 mon_e.stall, mon_e.flush, mon_e.we, mon_e.fault);
      end
    end
  end

  task automatic expect_cyc(input string name, input logic [5:0] st, input logic fl,
                            input logic we, input logic flt);
    exp_t e;
    e.name  = name;
    e.stall = st;
    e.flush = fl;
    e.we    = we;
    e.fault = flt;
    sb_q.push_back(e);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge ck_i);
    #1;
  endtask

  task automatic set_in(input logic id, input logic ex, input logic req, input logic ack,
                        input logic [31:0] exc);
    stall_req_id_i = id;
    stall_req_ex_i = ex;
    mem_req_i      = req;
    mem_ack_i      = ack;
    exception_i    = exc;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rs_i = 1'b1;
    cyc();
    rs_i = 1'b0;
  endtask

  // Access that never acks: fault on the 15th MEM_WAIT cycle, then a trap.
  task automatic run_timeout(input string tag);
    mem_pc_i = 32'h8000_0010;
    mtvec_i  = 32'h8000_0100;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_cyc({tag, "_enter"}, 6'b011111, 1'b0, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k < 15; k++) begin
      expect_cyc($sformatf("%s_wait%0d", tag, k), 6'b011111, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    expect_cyc({tag, "_fault"}, 6'b011111, 1'b0, 1'b0, 1'b1);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc({tag, "_trap"}, 6'b000000, 1'b1, 1'b1, 1'b0);
    chk32({tag, "_new_pc"}, new_pc_o, 32'h8000_0100);
    chk32({tag, "_epc"}, epc_o, 32'h8000_0010);
    cyc();
    expect_cyc({tag, "_run"}, 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"v_idle",       1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000};
    vecs[1]  = '{"v_id",         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000111};
    vecs[2]  = '{"v_ex",         1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b001111};
    vecs[3]  = '{"v_ex_id",      1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6'b001111};
    vecs[4]  = '{"v_mem",        1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b011111};
    vecs[5]  = '{"v_mem_ack",    1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 6'b000000};
    vecs[6]  = '{"v_ack_ex",     1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 6'b001111};
    vecs[7]  = '{"v_mem_ex_id",  1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 6'b011111};
    vecs[8]  = '{"v_exc",        1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 6'b111111};
    vecs[9]  = '{"v_exc_mem",    1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 6'b111111};
    vecs[10] = '{"v_exc_ack_ex", 1'b1, 1'b1, 1'b1, 1'b1, 32'h2, 6'b111111};

    mtvec_i  = 32'h0;
    mem_pc_i = 32'h0;
    do_reset();

    // Reset state
    expect_cyc("reset_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk32("reset_cnt", stall_cnt_o, 32'h0);
    chk32("reset_epc", epc_o, 32'h0);
    chk32("reset_new_pc", new_pc_o, 32'h0);
    cyc();

    // Single-cycle priority table from RUN
    for (int i = 0; i < 11; i++) begin
      do_reset();
      set_in(vecs[i].id, vecs[i].ex, vecs[i].req, vecs[i].ack, vecs[i].exc);
      expect_cyc(vecs[i].name, vecs[i].stall, 1'b0, 1'b0, 1'b0);
      cyc();
      chk32({vecs[i].name, "_cnt"}, stall_cnt_o, (vecs[i].stall != 6'b0) ? 32'd1 : 32'd0);
    end

    // One-cycle load-use stall
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("id1_stall", 6'b000111, 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk32("id1_cnt", stall_cnt_o, 32'd1);
    expect_cyc("id1_after", 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("id1_cnt_hold", stall_cnt_o, 32'd1);

    // Memory wait of three cycles, ack on the fourth
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      expect_cyc($sformatf("mw_wait%0d", k), 6'b011111, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    expect_cyc("mw_ack", 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();
    // Back in RUN: an ID request is honoured (MEM_WAIT would ignore it)
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("mw_run", 6'b000111, 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk32("mw_cnt", stall_cnt_o, 32'd4);

    // Timeout fault
    do_reset();
    run_timeout("tmo");

    // Exception with ack and EX busy; exception ignored while in TRAP
    do_reset();
    mem_pc_i = 32'h0000_1234;
    mtvec_i  = 32'h0000_5678;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h2);
    expect_cyc("exc_enter", 6'b111111, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("exc_epc", epc_o, 32'h0000_1234);
    chk32("exc_new_pc", new_pc_o, 32'h0000_5678);
    mem_pc_i = 32'h0000_9999;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
    expect_cyc("exc_trap", 6'b000000, 1'b1, 1'b1, 1'b0);
    cyc();
    chk32("exc_epc_kept", epc_o, 32'h0000_1234);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("exc_run", 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();

    // Exception arriving during MEM_WAIT
    mem_pc_i = 32'h0000_AAA0;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_cyc("mwexc_wait", 6'b011111, 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h4);
    expect_cyc("mwexc_enter", 6'b111111, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("mwexc_epc", epc_o, 32'h0000_AAA0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("mwexc_trap", 6'b000000, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_cyc("mwexc_run", 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();

    // Reset in the middle of MEM_WAIT
    do_reset();
    mem_pc_i = 32'h0000_0040;
    mtvec_i  = 32'h0000_0080;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h1);
    expect_cyc("rst_exc", 6'b111111, 1'b0, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_cyc("rst_trap", 6'b000000, 1'b1, 1'b1, 1'b0);
    cyc();
    expect_cyc("rst_mw_enter", 6'b011111, 1'b0, 1'b0, 1'b0);
    cyc();
    expect_cyc("rst_mw1", 6'b011111, 1'b0, 1'b0, 1'b0);
    cyc();
    rs_i = 1'b1;
    cyc();
    rs_i = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("rst_after", 6'b000000, 1'b0, 1'b0, 1'b0);
    chk32("rst_epc", epc_o, 32'h0);
    chk32("rst_new_pc", new_pc_o, 32'h0);
    chk32("rst_cnt", stall_cnt_o, 32'h0);
    cyc();
    run_timeout("rst_tmo");

    // Stall counter saturation
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    expect_cyc("sat_ex0", 6'b001111, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("sat_cnt0", stall_cnt_o, 32'hFFFF_FFFF);
    expect_cyc("sat_ex1", 6'b001111, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("sat_cnt1", stall_cnt_o, 32'hFFFF_FFFF);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_cyc("sat_idle", 6'b000000, 1'b0, 1'b0, 1'b0);
    cyc();
    chk32("sat_cnt2", stall_cnt_o, 32'hFFFF_FFFF);

    cyc();
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data and PC width.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM_WAIT cycles before an access fault.
REQ-003 The block SHALL have port ck_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rs_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port stall_req_id_i, input, 1 bit: load-use hazard request from ID.
REQ-006 The block SHALL have port stall_req_ex_i, input, 1 bit: multi-cycle EX operation (e.g. divide) busy.
REQ-007 The block SHALL have ports mem_req_i and mem_ack_i, input, 1 bit each: LSU access pending, and LSU access complete.
REQ-008 The block SHALL have port exception_i, input, XLEN bits: MEM-stage exception vector; non-zero means trap.
REQ-009 The block SHALL have ports mtvec_i and mem_pc_i, input, XLEN bits each: trap vector base, and PC of the MEM-stage instruction.
REQ-010 The block SHALL have port stall_o, output, 6 bits: stage stall vector; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP.
REQ-011 The block SHALL have port flush_o, output, 1 bit: flush all pipeline registers.
REQ-012 The block SHALL have ports new_pc_we_o, output, 1 bit, and new_pc_o, output, XLEN bits: PC redirect.
REQ-013 The block SHALL have ports epc_o, output, XLEN bits, and mem_fault_o, output, 1 bit: captured trap PC, and timeout fault pulse.
REQ-014 The block SHALL have port stall_cnt_o, output, 32 bits: count of stalled cycles.

Function
REQ-015 The FSM SHALL have states RUN, MEM_WAIT and TRAP.
REQ-016 stall_o SHALL be combinational from the current state and inputs, with priority: exception > memory > EX > ID.
REQ-017 In RUN or MEM_WAIT with exception_i != 0, the block SHALL drive stall_o=6'b111111, capture epc_o<=mem_pc_i and new_pc_o<=mtvec_i, and enter TRAP.
REQ-018 In TRAP, flush_o=1 and new_pc_we_o=1 SHALL hold for exactly one cycle, stall_o SHALL be 0, and the next state SHALL be RUN; exception_i SHALL be ignored in TRAP.
REQ-019 In RUN with mem_req_i=1 and mem_ack_i=0, the block SHALL drive stall_o=6'b011111 and enter MEM_WAIT with the timeout counter at 1.
REQ-020 In MEM_WAIT, while mem_ack_i=0 the block SHALL hold stall_o=6'b011111 and increment the timeout counter; on mem_ack_i=1 it SHALL drive stall_o=0 in that cycle and return to RUN.
REQ-021 When the timeout counter equals MEM_TIMEOUT with mem_ack_i=0, the block SHALL pulse mem_fault_o for 1 cycle, capture epc_o<=mem_pc_i and new_pc_o<=mtvec_i, and enter TRAP.
REQ-022 mem_req_i=1 with mem_ack_i=1 in the same RUN cycle SHALL cause no stall.
REQ-023 In RUN with no memory stall: stall_req_ex_i=1 SHALL give stall_o=6'b001111; otherwise stall_req_id_i=1 SHALL give 6'b000111 (bubble into EX); otherwise 0.
REQ-024 An exception together with mem_ack_i in the same cycle SHALL take the exception path.
REQ-025 stall_cnt_o SHALL increment by 1 each cycle stall_o != 0 and saturate at 32'hFFFFFFFF.

Reset
REQ-026 On rs_i=1 at a clock edge, the block SHALL enter RUN, clear the timeout counter, and set flush_o=0, new_pc_we_o=0, new_pc_o=0, epc_o=0, mem_fault_o=0, stall_o=0 and stall_cnt_o=0.
REQ-027 Reset SHALL override any state, including mid MEM_WAIT or TRAP, with no pending flush surviving.

Verification
REQ-028 Bench: stall_req_id_i=1 for 1 cycle -> stall_o=6'b000111 that cycle; stall_cnt_o=1.
REQ-029 Bench: mem_req_i=1, mem_ack_i low for 3 cycles then high -> stall_o=6'b011111 for 3 cycles, 0 on the ack cycle, state back to RUN.
REQ-030 Bench: MEM_TIMEOUT=15, ack never arrives, mem_pc_i=0x80000010, mtvec_i=0x80000100 -> mem_fault_o pulse after 15 wait cycles; next cycle flush_o=1, new_pc_we_o=1, new_pc_o=0x80000100, epc_o=0x80000010.
REQ-031 Bench: exception_i=0x2 with mem_ack_i=1 and stall_req_ex_i=1 in the same cycle -> stall_o=6'b111111, then 1-cycle flush, then RUN.
REQ-032 Bench: rs_i=1 asserted in the 2nd MEM_WAIT cycle -> next cycle all outputs 0, state RUN; a later mem access times out only after a full 15 cycles.
REQ-033 Bench: stall_cnt_o preloaded to 32'hFFFFFFFE via a forced stall sequence -> stays at 32'hFFFFFFFF after saturation.
